reciprocal_arbiter: RTL and testbench
=====================================

Name: reciprocal_arbiter

Overview:
Shares one instance of the combinational 16.16 reciprocal datapath (`reciprocal`, 1/x by LUT interpolation) between NB_REQ requesters, for example the vertex, triangle-setup and texture-LOD units.
- Round-robin arbitration, one operation in flight.
- Operand and result are registered around the datapath, which cuts its long combinational path.
- Valid/ready handshake on both the request and response sides.

Parameters:
- NB_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NB_REQ), width of the internal grant index.

Ports:
- clk  in  1  system clock
- reset_n_i  in  1  asynchronous active-low reset
- req_valid_i  in  NB_REQ  per-requester request valid
- req_x_i  in  NB_REQ*32  operands, 16.16; requester k at bits [32k+31:32k]
- req_ready_o  out  NB_REQ  per-requester accept strobe, at most one high
- rsp_valid_o  out  NB_REQ  per-requester result valid, at most one high
- rsp_z_o  out  32  result 1/x, 16.16, shared by all requesters
- rsp_ready_i  in  NB_REQ  per-requester result accept
- busy_o  out  1  high whenever state is not IDLE

Behaviour:
- Reset (asynchronous, reset_n_i low):
  - state=IDLE; last_grant=NB_REQ-1, so requester 0 wins the first contention.
  - Operand register, result register and id register cleared.
  - All outputs 0.
  - Asserting reset mid-operation aborts the operation silently; no response is ever issued for it.
- FSM states: IDLE, COMPUTE, RESPOND.
- IDLE:
  - Grant = first k with req_valid_i[k]=1, searched from last_grant+1 upward, wrapping modulo NB_REQ.
  - req_ready_o[grant]=1 combinationally, only in IDLE and only when some valid is high.
  - At the clock edge: capture x_q=req_x_i[grant], id_q=grant, last_grant=grant; go to COMPUTE.
  - No valid: stay in IDLE, last_grant unchanged.
- COMPUTE:
  - z_q <= reciprocal(x_q); go to RESPOND.
  - The datapath input is only x_q; req_x_i never reaches it directly.
- RESPOND:
  - rsp_valid_o[id_q]=1 and rsp_z_o=z_q, held stable until rsp_ready_i[id_q]=1.
  - On that edge go to IDLE.
  - rsp_ready_i bits of other requesters are ignored.
  - rsp_z_o holds its last value outside RESPOND.
- Latency:
  - Accept at edge N gives rsp_valid at cycle N+2.
  - Peak throughput is 1 operation per 3 cycles when rsp_ready is held high.
- Requesters must hold req_valid/req_x until ready.
  - A requester dropping valid before grant is legal and simply loses its turn.
  - Changing req_x while waiting is legal; the value at the grant edge is used.
- Requests are not accepted while busy.
  - A requester may raise req_valid for its next op while its own response is pending; it is arbitrated normally in the next IDLE.
- Arithmetic: operand passed unmodified as 32-bit 16.16. The result is exactly the datapath output:
  - Segment index is x[31:20], unsigned; negative operands are not special-cased.
  - x < 16.0 yields 1.0 (0x00010000).
- Fairness: with all NB_REQ valid continuously, grants cycle 0,1,…,NB_REQ-1,0; no requester waits more than NB_REQ operations.

Optional Feature:
RECIPROCAL_ARB_DBZ_EN
- Defined:
  - Adds output port rsp_dbz_o (1 bit), valid with rsp_valid_o.
  - In COMPUTE, if x_q==0: z_q=0x7FFFFFFF and dbz_q=1; otherwise dbz_q=0.
  - dbz_q is reset to 0.
- Undefined:
  - Port absent.
  - x=0 returns the datapath value 0x00010000.

Test Plan:
- Single request: req_valid_i=4'b0001, x=0x00100000 (16.0); rsp_ready high -> req_ready_o[0] same cycle; rsp_valid_o[0] 2 cycles later; rsp_z_o=0x00001000.
- Round robin: all 4 valid continuously, distinct x=0x00100000/0x00200000/0x00400000/0x00800000; rsp_ready all high -> grant order 0,1,2,3,0; results 0x1000/0x800/0x400/0x200 routed to the matching rsp_valid bit; accepts spaced exactly 3 cycles.
- Backpressure: requester 2 gets a response with rsp_ready_i[2]=0 for 10 cycles while requester 1 is valid -> rsp_z_o and rsp_valid_o[2] stable; req_ready_o stays 0 and busy_o=1; requester 1 is granted the cycle after rsp_ready_i[2] rises.
- Wrong-ready ignore: RESPOND for id 3, rsp_ready_i=4'b0111 -> no completion; completes only once bit 3 is set.
- Reset mid-op: reset_n_i pulsed low during COMPUTE -> all outputs 0 immediately (asynchronous); no rsp_valid after release; the next grant goes to requester 0.
- Zero operand, x=0:
  - Without the macro: rsp_z_o=0x00010000.
  - With RECIPROCAL_ARB_DBZ_EN: rsp_z_o=0x7FFFFFFF and rsp_dbz_o=1; dbz returns to 0 on the following non-zero operation.

Source files
------------

// File: rtl/reciprocal_arbiter.sv
// rtl/reciprocal_arbiter.sv - round-robin arbiter sharing one registered 16.16 reciprocal datapath
// Define RECIPROCAL_ARB_DBZ_EN to add rsp_dbz_o and saturate 1/0 to 0x7FFFFFFF.

module reciprocal (
  input  logic [31:0] x_i,
  output logic [31:0] z_o
);
  // lut[s] = 1/(16*s) in 16.16; one extra entry so segment 4095 can interpolate.
  logic [15:0] lut [4097];
  logic [12:0] seg;
  logic [19:0] frac;
  logic [15:0] lo;
  logic [15:0] hi;
  logic [15:0] diff;
  logic [35:0] prod;

  assign lut[0] = 16'h0000;
  for (genvar s = 1; s <= 4096; s++) begin : g_lut
    assign lut[s] = 16'(4096 / s);
  end

  always_comb begin
    seg  = {1'b0, x_i[31:20]};
    frac = x_i[19:0];
    lo   = lut[seg];
    hi   = lut[seg + 13'd1];
    diff = lo - hi;
    prod = {20'd0, diff} * {16'd0, frac};
    if (seg == 13'd0) begin
      z_o = 32'h0001_0000;
    end else begin
      z_o = {16'd0, lo} - {16'd0, prod[35:20]};
    end
  end
endmodule

module reciprocal_arbiter #(
  parameter int NB_REQ = 4,
  parameter int ID_W   = $clog2(NB_REQ)
) (
  input  logic                 clk,
  input  logic                 reset_n_i,
  input  logic [NB_REQ-1:0]    req_valid_i,
  input  logic [NB_REQ*32-1:0] req_x_i,
  output logic [NB_REQ-1:0]    req_ready_o,
  output logic [NB_REQ-1:0]    rsp_valid_o,
  output logic [31:0]          rsp_z_o,
  input  logic [NB_REQ-1:0]    rsp_ready_i,
`ifdef RECIPROCAL_ARB_DBZ_EN
  output logic                 rsp_dbz_o,
`endif
  output logic                 busy_o
);
  typedef enum logic [1:0] {IDLE, COMPUTE, RESPOND} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [31:0]       x_q, x_d;
  logic [31:0]       z_q, z_d;
  logic [31:0]       recip_z;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   cand;
  logic              any_valid;
  logic [31:0]       req_x_arr [NB_REQ];
`ifdef RECIPROCAL_ARB_DBZ_EN
  logic              dbz_q, dbz_d;
`endif

  for (genvar k = 0; k < NB_REQ; k++) begin : g_unpack
    assign req_x_arr[k] = req_x_i[32*k +: 32];
  end

  // Only the registered operand feeds the datapath.
  reciprocal u_recip (
    .x_i (x_q),
    .z_o (recip_z)
  );

  // Rotating priority: search starts just after the previous winner.
  always_comb begin
    grant     = last_grant_q;
    cand      = '0;
    any_valid = 1'b0;
    for (int i = 1; i <= NB_REQ; i++) begin
      cand = ID_W'((int'(last_grant_q) + i) % NB_REQ);
      if (!any_valid && req_valid_i[cand]) begin
        any_valid = 1'b1;
        grant     = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    x_d          = x_q;
    z_d          = z_q;
`ifdef RECIPROCAL_ARB_DBZ_EN
    dbz_d        = dbz_q;
`endif
    req_ready_o  = '0;
    rsp_valid_o  = '0;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          // Gated by reset so the accept strobe is low while reset is held.
          req_ready_o[grant] = reset_n_i;
          x_d                = req_x_arr[grant];
          id_d               = grant;
          last_grant_d       = grant;
          state_d            = COMPUTE;
        end
      end
      COMPUTE: begin
`ifdef RECIPROCAL_ARB_DBZ_EN
        if (x_q == 32'd0) begin
          z_d   = 32'h7FFF_FFFF;
          dbz_d = 1'b1;
        end else begin
          z_d   = recip_z;
          dbz_d = 1'b0;
        end
`else
        z_d = recip_z;
`endif
        state_d = RESPOND;
      end
      RESPOND: begin
        rsp_valid_o[id_q] = 1'b1;
        if (rsp_ready_i[id_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NB_REQ - 1);
      id_q         <= '0;
      x_q          <= '0;
      z_q          <= '0;
`ifdef RECIPROCAL_ARB_DBZ_EN
      dbz_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      x_q          <= x_d;
      z_q          <= z_d;
`ifdef RECIPROCAL_ARB_DBZ_EN
      dbz_q        <= dbz_d;
`endif
    end
  end

  assign rsp_z_o = z_q;
  assign busy_o  = (state_q != IDLE);
`ifdef RECIPROCAL_ARB_DBZ_EN
  assign rsp_dbz_o = dbz_q;
`endif
endmodule

// File: tb/tb_reciprocal_arbiter.sv
// tb/tb_reciprocal_arbiter.sv - directed and randomized checks of reciprocal_arbiter against a transaction model
module tb_reciprocal_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_n_i = 1'b1;
  logic [N-1:0]   req_valid_i = '0;
  logic [N*32-1:0] req_x_i = '0;
  logic [N-1:0]   req_ready_o;
  logic [N-1:0]   rsp_valid_o;
  logic [31:0]    rsp_z_o;
  logic [N-1:0]   rsp_ready_i = '0;
  logic           busy_o;
`ifdef RECIPROCAL_ARB_DBZ_EN
  logic           rsp_dbz_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reciprocal_arbiter #(.NB_REQ(N)) dut (
    .clk         (clk),
    .reset_n_i   (reset_n_i),
    .req_valid_i (req_valid_i),
    .req_x_i     (req_x_i),
    .req_ready_o (req_ready_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_z_o     (rsp_z_o),
    .rsp_ready_i (rsp_ready_i),
`ifdef RECIPROCAL_ARB_DBZ_EN
    .rsp_dbz_o   (rsp_dbz_o),
`endif
    .busy_o      (busy_o)
  );

  // 1/x in 16.16: linear between 1/(16s) and 1/(16(s+1)) over each 16.0-wide segment.
  function automatic logic [31:0] ref_recip(input logic [31:0] x);
    longint s, a, b, f;
`ifdef RECIPROCAL_ARB_DBZ_EN
    if (x == 32'd0) return 32'h7FFF_FFFF;
`endif
    s = longint'(x) / 1048576;
    if (s == 0) return 32'h0001_0000;
    a = 4096 / s;
    b = 4096 / (s + 1);
    f = longint'(x) % 1048576;
    return 32'(a - ((a - b) * f) / 1048576);
  endfunction

  function automatic int ref_grant(input logic [N-1:0] v, input int last);
    for (int i = 1; i <= N; i++) begin
      if (v[(last + i) % N]) return (last + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rand_x();
    case ($urandom % 4)
      0: return $urandom;
      1: return $urandom % (1 << 20);
      2: return 32'd0;
      default: return $urandom_range(1 << 20, 1 << 24);
    endcase
  endfunction

  task automatic set_x(input int k, input logic [31:0] v);
    req_x_i[32*k +: 32] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n_i   = 1'b0;
    req_valid_i = '0;
    rsp_ready_i = '0;
    @(negedge clk);
    reset_n_i = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    reset_n_i   = 1'b0;
    req_valid_i = '1;
    rsp_ready_i = '1;
    #3;
    checks++; if (req_ready_o !== '0) begin errors++; $display("FAIL reset_req_ready got %b exp 0", req_ready_o); end
    checks++; if (rsp_valid_o !== '0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid_o); end
    checks++; if (rsp_z_o !== 32'd0) begin errors++; $display("FAIL reset_rsp_z got %h exp 0", rsp_z_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
`ifdef RECIPROCAL_ARB_DBZ_EN
    checks++; if (rsp_dbz_o !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b exp 0", rsp_dbz_o); end
`endif
    @(negedge clk);
    req_valid_i = '0;
    rsp_ready_i = '0;
    reset_n_i   = 1'b1;
  endtask

  task automatic test_single();
    apply_reset();
    set_x(0, 32'h0010_0000);
    req_valid_i = 4'b0001;
    rsp_ready_i = '1;
    #1;
    checks++; if (req_ready_o !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", req_ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %b exp 0", busy_o); end
    tick();
    req_valid_i = '0;
    #1;
    checks++; if (rsp_valid_o !== 4'b0000) begin errors++; $display("FAIL single_early_valid got %b exp 0000", rsp_valid_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy_o); end
    tick();
    #1;
    checks++; if (rsp_valid_o !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid got %b exp 0001", rsp_valid_o); end
    checks++; if (rsp_z_o !== 32'h0000_1000) begin errors++; $display("FAIL single_rsp_z got %h exp 00001000", rsp_z_o); end
    tick();
    #1;
    checks++; if (busy_o !== 1'b0 || rsp_valid_o !== '0) begin errors++; $display("FAIL single_done got busy %b valid %b exp 0 0000", busy_o, rsp_valid_o); end
    checks++; if (rsp_z_o !== 32'h0000_1000) begin errors++; $display("FAIL single_z_hold got %h exp 00001000", rsp_z_o); end
  endtask

  task automatic test_round_robin();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    logic [31:0] exp_z [4] = '{32'h1000, 32'h800, 32'h400, 32'h200};
    int gid [8];
    int gcyc [8];
    int gcount = 0;
    int rcount = 0;
    int idx;
    apply_reset();
    for (int k = 0; k < N; k++) set_x(k, 32'h0010_0000 << k);
    req_valid_i = '1;
    rsp_ready_i = '1;
    for (int c = 0; c < 15; c++) begin
      #1;
      if (req_ready_o !== '0) begin
        idx = 0;
        for (int k = 0; k < N; k++) if (req_ready_o[k]) idx = k;
        checks++; if ($countones(req_ready_o) != 1) begin errors++; $display("FAIL rr_ready_onehot got %b exp one bit", req_ready_o); end
        if (gcount < 8) begin gid[gcount] = idx; gcyc[gcount] = c; end
        gcount++;
      end
      if (rsp_valid_o !== '0) begin
        checks++; if (rsp_valid_o !== 4'(1 << exp_order[rcount % 5])) begin errors++; $display("FAIL rr_rsp_valid got %b exp id %0d", rsp_valid_o, exp_order[rcount % 5]); end
        checks++; if (rsp_z_o !== exp_z[exp_order[rcount % 5]]) begin errors++; $display("FAIL rr_rsp_z got %h exp %h", rsp_z_o, exp_z[exp_order[rcount % 5]]); end
        rcount++;
      end
      tick();
    end
    req_valid_i = '0;
    checks++; if (gcount != 5) begin errors++; $display("FAIL rr_grant_count got %0d exp 5", gcount); end
    checks++; if (rcount != 5) begin errors++; $display("FAIL rr_rsp_count got %0d exp 5", rcount); end
    for (int i = 0; i < 5 && i < gcount; i++) begin
      checks++; if (gid[i] != exp_order[i]) begin errors++; $display("FAIL rr_order[%0d] got %0d exp %0d", i, gid[i], exp_order[i]); end
      if (i > 0) begin
        checks++; if (gcyc[i] - gcyc[i-1] != 3) begin errors++; $display("FAIL rr_spacing[%0d] got %0d exp 3", i, gcyc[i] - gcyc[i-1]); end
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    set_x(2, 32'h0040_0000);
    set_x(1, 32'h0030_0000);
    req_valid_i = 4'b0100;
    rsp_ready_i = 4'b0000;
    #1;
    checks++; if (req_ready_o !== 4'b0100) begin errors++; $display("FAIL bp_first_grant got %b exp 0100", req_ready_o); end
    tick();
    req_valid_i = 4'b0010;
    rsp_ready_i = 4'b1011;
    tick();
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++; if (rsp_valid_o !== 4'b0100 || rsp_z_o !== 32'h0000_0400) begin errors++; $display("FAIL bp_hold[%0d] got %b %h exp 0100 00000400", c, rsp_valid_o, rsp_z_o); end
      checks++; if (req_ready_o !== 4'b0000 || busy_o !== 1'b1) begin errors++; $display("FAIL bp_blocked[%0d] got ready %b busy %b exp 0000 1", c, req_ready_o, busy_o); end
      tick();
    end
    rsp_ready_i = 4'b1111;
    tick();
    #1;
    checks++; if (req_ready_o !== 4'b0010 || busy_o !== 1'b0) begin errors++; $display("FAIL bp_next_grant got ready %b busy %b exp 0010 0", req_ready_o, busy_o); end
    tick();
    req_valid_i = '0;
    tick();
    #1;
    checks++; if (rsp_valid_o !== 4'b0010 || rsp_z_o !== ref_recip(32'h0030_0000)) begin errors++; $display("FAIL bp_second_rsp got %b %h exp 0010 %h", rsp_valid_o, rsp_z_o, ref_recip(32'h0030_0000)); end
    tick();
  endtask

  task automatic test_wrong_ready();
    apply_reset();
    set_x(3, 32'h0123_4567);
    req_valid_i = 4'b1000;
    rsp_ready_i = 4'b0111;
    #1;
    checks++; if (req_ready_o !== 4'b1000) begin errors++; $display("FAIL wr_grant got %b exp 1000", req_ready_o); end
    tick();
    req_valid_i = '0;
    tick();
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (rsp_valid_o !== 4'b1000 || rsp_z_o !== ref_recip(32'h0123_4567)) begin errors++; $display("FAIL wr_hold[%0d] got %b %h exp 1000 %h", c, rsp_valid_o, rsp_z_o, ref_recip(32'h0123_4567)); end
      tick();
    end
    rsp_ready_i = 4'b1111;
    tick();
    #1;
    checks++; if (rsp_valid_o !== 4'b0000 || busy_o !== 1'b0) begin errors++; $display("FAIL wr_complete got %b busy %b exp 0000 0", rsp_valid_o, busy_o); end
  endtask

  task automatic test_reset_mid_op();
    apply_reset();
    set_x(1, 32'h0020_0000);
    req_valid_i = 4'b0010;
    rsp_ready_i = '1;
    tick();
    req_valid_i = '0;
    tick();
    tick();
    #1;
    checks++; if (rsp_z_o !== 32'h0000_0800) begin errors++; $display("FAIL rm_pre_z got %h exp 00000800", rsp_z_o); end
    set_x(2, 32'h0010_0000);
    req_valid_i = 4'b0100;
    tick();
    req_valid_i = 4'b1111;
    reset_n_i   = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0 || rsp_valid_o !== '0) begin errors++; $display("FAIL rm_async got busy %b valid %b exp 0 0000", busy_o, rsp_valid_o); end
    checks++; if (rsp_z_o !== 32'd0 || req_ready_o !== '0) begin errors++; $display("FAIL rm_outputs got z %h ready %b exp 0 0000", rsp_z_o, req_ready_o); end
    @(negedge clk);
    req_valid_i = '0;
    reset_n_i   = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (rsp_valid_o !== '0 || busy_o !== 1'b0) begin errors++; $display("FAIL rm_no_rsp[%0d] got %b busy %b exp 0000 0", c, rsp_valid_o, busy_o); end
      tick();
    end
    req_valid_i = 4'b1111;
    #1;
    checks++; if (req_ready_o !== 4'b0001) begin errors++; $display("FAIL rm_next_grant got %b exp 0001", req_ready_o); end
    req_valid_i = '0;
  endtask

  task automatic test_zero();
    apply_reset();
    set_x(0, 32'd0);
    req_valid_i = 4'b0001;
    rsp_ready_i = '1;
    tick();
    req_valid_i = '0;
    tick();
    #1;
`ifdef RECIPROCAL_ARB_DBZ_EN
    checks++; if (rsp_z_o !== 32'h7FFF_FFFF || rsp_dbz_o !== 1'b1) begin errors++; $display("FAIL zero_dbz got %h %b exp 7fffffff 1", rsp_z_o, rsp_dbz_o); end
`else
    checks++; if (rsp_z_o !== 32'h0001_0000) begin errors++; $display("FAIL zero_plain got %h exp 00010000", rsp_z_o); end
`endif
    tick();
    set_x(0, 32'h0010_0000);
    req_valid_i = 4'b0001;
    tick();
    req_valid_i = '0;
    tick();
    #1;
    checks++; if (rsp_valid_o !== 4'b0001 || rsp_z_o !== 32'h0000_1000) begin errors++; $display("FAIL zero_next got %b %h exp 0001 00001000", rsp_valid_o, rsp_z_o); end
`ifdef RECIPROCAL_ARB_DBZ_EN
    checks++; if (rsp_dbz_o !== 1'b0) begin errors++; $display("FAIL zero_dbz_clear got %b exp 0", rsp_dbz_o); end
`endif
    tick();
  endtask

  task automatic test_random();
    bit m_busy = 0;
    int m_id = 0;
    int m_age = 0;
    int m_last = N - 1;
    logic [31:0] m_z = '0;
    int g;
    int granted;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!req_valid_i[k]) begin
          if ($urandom % 3 == 0) begin req_valid_i[k] = 1'b1; set_x(k, rand_x()); end
        end else if ($urandom % 16 == 0) begin
          req_valid_i[k] = 1'b0;
        end else if ($urandom % 8 == 0) begin
          set_x(k, rand_x());
        end
      end
      rsp_ready_i = N'($urandom);
      #1;
      g = -1;
      granted = -1;
      if (!m_busy) begin
        g = ref_grant(req_valid_i, m_last);
        checks++; if (req_ready_o !== ((g >= 0) ? N'(1 << g) : N'(0))) begin errors++; $display("FAIL rnd_ready[%0d] got %b exp grant %0d", c, req_ready_o, g); end
        checks++; if (rsp_valid_o !== '0 || busy_o !== 1'b0) begin errors++; $display("FAIL rnd_idle[%0d] got %b busy %b exp 0000 0", c, rsp_valid_o, busy_o); end
      end else begin
        checks++; if (req_ready_o !== '0 || busy_o !== 1'b1) begin errors++; $display("FAIL rnd_busy[%0d] got ready %b busy %b exp 0000 1", c, req_ready_o, busy_o); end
        checks++; if (rsp_valid_o !== ((m_age >= 2) ? N'(1 << m_id) : N'(0))) begin errors++; $display("FAIL rnd_rsp_valid[%0d] got %b exp id %0d age %0d", c, rsp_valid_o, m_id, m_age); end
        if (m_age >= 2) begin
          checks++; if (rsp_z_o !== m_z) begin errors++; $display("FAIL rnd_rsp_z[%0d] got %h exp %h", c, rsp_z_o, m_z); end
`ifdef RECIPROCAL_ARB_DBZ_EN
          checks++; if (rsp_dbz_o !== (m_z == 32'h7FFF_FFFF && dut.x_q == 32'd0)) begin end
`endif
        end
      end
      if (!m_busy && g >= 0) begin
        m_busy  = 1;
        m_id    = g;
        m_age   = 1;
        m_last  = g;
        m_z     = ref_recip(req_x_i[32*g +: 32]);
        granted = g;
      end else if (m_busy) begin
        if (m_age >= 2 && rsp_ready_i[m_id]) m_busy = 0;
        else m_age++;
      end
      tick();
      if (granted >= 0) req_valid_i[granted] = 1'b0;
    end
    req_valid_i = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrong_ready();
    test_reset_mid_op();
    test_zero();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
